// File: rtl/id_stage_if.sv
// Signal bundle between id_stage and its neighbours: fetch, register file, forwarding
// sources and the ID/EX latch. The slave modport is the decode stage's view.
interface id_stage_if #(
    parameter int STALL_CNT_W = 16
);
    logic [31:0]            Instruction_F;
    logic [31:0]            NPC_F;
    logic [3:0]             RegA_addr;
    logic [3:0]             RegB_addr;
    logic [31:0]            RegA_data;
    logic [31:0]            RegB_data;
    logic [5:0]             Fwd_E;
    logic [31:0]            Result_E;
    logic [5:0]             Fwd_M;
    logic [31:0]            Result_M;
    logic [4:0]             Fwd_W;
    logic [31:0]            Result_W;
    logic [1:0]             PCsrc;
    logic [31:0]            PC_offset;
    logic [31:0]            PC_regRs;
    logic                   KILL;
    logic                   disable_PC;
    logic                   disable_IR;
    logic [5:0]             Ctrl_D;
    logic [3:0]             Rd_D;
    logic [31:0]            A_D;
    logic [31:0]            B_D;
    logic [31:0]            Imm_D;
    logic [31:0]            NPC_D;
    logic [STALL_CNT_W-1:0] stall_count;

    modport slave (
        input  Instruction_F, NPC_F, RegA_data, RegB_data,
        input  Fwd_E, Result_E, Fwd_M, Result_M, Fwd_W, Result_W,
        output RegA_addr, RegB_addr,
        output PCsrc, PC_offset, PC_regRs, KILL, disable_PC, disable_IR,
        output Ctrl_D, Rd_D, A_D, B_D, Imm_D, NPC_D, stall_count
    );

    modport master (
        output Instruction_F, NPC_F, RegA_data, RegB_data,
        output Fwd_E, Result_E, Fwd_M, Result_M, Fwd_W, Result_W,
        input  RegA_addr, RegB_addr,
        input  PCsrc, PC_offset, PC_regRs, KILL, disable_PC, disable_IR,
        input  Ctrl_D, Rd_D, A_D, B_D, Imm_D, NPC_D, stall_count
    );
endinterface

// File: rtl/id_stage.sv
// Instruction decode: operand hazard handling, decode-time jump/branch resolution, ID/EX latch.
// Define ID_FWD_EN for the forwarding build; undefined gives register-file operands with full stalling.
module id_stage #(
    parameter int STALL_CNT_W = 16
) (
    input logic       clk,
    input logic       reset,
    id_stage_if.slave bus
);
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h05;
    localparam logic [5:0] OP_ANDI = 6'h06;
    localparam logic [5:0] OP_LW   = 6'h07;
    localparam logic [5:0] OP_SW   = 6'h08;
    localparam logic [5:0] OP_BEQ  = 6'h09;
    localparam logic [5:0] OP_BNE  = 6'h0A;
    localparam logic [5:0] OP_J    = 6'h0B;
    localparam logic [5:0] OP_CALL = 6'h0C;
    localparam logic [5:0] OP_JR   = 6'h0D;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    function automatic logic signed [31:0] sext14(input logic [13:0] v);
        return {{18{v[13]}}, v};
    endfunction

    function automatic logic signed [31:0] sext26(input logic [25:0] v);
        return {{6{v[25]}}, v};
    endfunction

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // R0 is hard-wired zero, so it never matches a producer.
    function automatic logic src_hit(input logic [3:0] src, input logic wr, input logic [3:0] dst);
        return wr && (dst == src) && (src != 4'd0);
    endfunction

    logic [5:0]  op;
    logic [3:0]  rd, rs, rt;
    logic [13:0] imm14;
    logic [25:0] imm26;

    assign op    = bus.Instruction_F[31:26];
    assign rd    = bus.Instruction_F[25:22];
    assign rs    = bus.Instruction_F[21:18];
    assign rt    = bus.Instruction_F[17:14];
    assign imm14 = bus.Instruction_F[13:0];
    assign imm26 = bus.Instruction_F[25:0];

    assign bus.RegA_addr = rs;
    assign bus.RegB_addr = rt;

    logic is_alu_r, is_addi, is_andi, is_lw, is_sw, is_beq, is_bne, is_j, is_call, is_jr;
    logic uses_rs, uses_rt;

    always_comb begin
        is_alu_r = 1'b0;
        is_addi  = 1'b0;
        is_andi  = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_call  = 1'b0;
        is_jr    = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: is_alu_r = 1'b1;
            OP_ADDI: is_addi = 1'b1;
            OP_ANDI: is_andi = 1'b1;
            OP_LW:   is_lw   = 1'b1;
            OP_SW:   is_sw   = 1'b1;
            OP_BEQ:  is_beq  = 1'b1;
            OP_BNE:  is_bne  = 1'b1;
            OP_J:    is_j    = 1'b1;
            OP_CALL: is_call = 1'b1;
            OP_JR:   is_jr   = 1'b1;
            default: ;
        endcase
    end

    assign uses_rs = is_alu_r | is_addi | is_andi | is_lw | is_sw | is_beq | is_bne | is_jr;
    assign uses_rt = is_alu_r | is_sw | is_beq | is_bne;

    logic e_a, e_b, m_a, m_b, w_a, w_b;
    logic [31:0] op_a, op_b;
    logic stall;

    assign e_a = src_hit(rs, bus.Fwd_E[5], bus.Fwd_E[3:0]);
    assign e_b = src_hit(rt, bus.Fwd_E[5], bus.Fwd_E[3:0]);
    assign m_a = src_hit(rs, bus.Fwd_M[5], bus.Fwd_M[3:0]);
    assign m_b = src_hit(rt, bus.Fwd_M[5], bus.Fwd_M[3:0]);
    assign w_a = src_hit(rs, bus.Fwd_W[4], bus.Fwd_W[3:0]);
    assign w_b = src_hit(rt, bus.Fwd_W[4], bus.Fwd_W[3:0]);

`ifdef ID_FWD_EN
    // A load in EX has no data yet; the following cycle it is in MEM and forwards from there.
    assign op_a  = (e_a && !bus.Fwd_E[4]) ? bus.Result_E :
                   m_a ? bus.Result_M : w_a ? bus.Result_W : bus.RegA_data;
    assign op_b  = (e_b && !bus.Fwd_E[4]) ? bus.Result_E :
                   m_b ? bus.Result_M : w_b ? bus.Result_W : bus.RegB_data;
    assign stall = bus.Fwd_E[4] && ((uses_rs && e_a) || (uses_rt && e_b));

    logic unused_fwd;
    assign unused_fwd = bus.Fwd_M[4];
`else
    assign op_a  = bus.RegA_data;
    assign op_b  = bus.RegB_data;
    assign stall = (uses_rs && (e_a || m_a || w_a)) || (uses_rt && (e_b || m_b || w_b));

    logic unused_fwd;
    assign unused_fwd = ^{bus.Fwd_E[4], bus.Fwd_M[4], bus.Result_E, bus.Result_M, bus.Result_W};
`endif

    logic [1:0]  pcsrc;
    logic [31:0] pc_offset, pc_regrs;

    always_comb begin
        pcsrc     = 2'b00;
        pc_offset = 32'd0;
        pc_regrs  = 32'd0;
        if (is_j || is_call)
            pc_offset = bus.NPC_F + $unsigned(sext26(imm26));
        else if (is_beq || is_bne)
            pc_offset = bus.NPC_F + $unsigned(sext14(imm14));
        if (is_jr)
            pc_regrs = op_a;
        // A stalled branch re-evaluates next cycle with valid operands, so no redirect now.
        if (!stall) begin
            if (is_j || is_call || (is_beq && op_a == op_b) || (is_bne && op_a != op_b))
                pcsrc = 2'b01;
            else if (is_jr)
                pcsrc = 2'b10;
        end
    end

    assign bus.PCsrc      = pcsrc;
    assign bus.PC_offset  = pc_offset;
    assign bus.PC_regRs   = pc_regrs;
    assign bus.KILL       = (pcsrc != 2'b00);
    assign bus.disable_PC = stall;
    assign bus.disable_IR = stall;

    logic [31:0] imm_ext;
    logic [5:0]  ctrl_n;
    logic [3:0]  rd_n;
    logic [31:0] a_n, b_n, imm_n;

    assign imm_ext = is_andi ? {18'd0, imm14} : $unsigned(sext14(imm14));

    always_comb begin
        ctrl_n = 6'd0;
        rd_n   = 4'd0;
        a_n    = uses_rs ? op_a : 32'd0;
        b_n    = uses_rt ? op_b : 32'd0;
        imm_n  = 32'd0;
        case (op)
            OP_ADD:  begin ctrl_n = {4'b1000, ALU_ADD}; rd_n = rd; end
            OP_SUB:  begin ctrl_n = {4'b1000, ALU_SUB}; rd_n = rd; end
            OP_AND:  begin ctrl_n = {4'b1000, ALU_AND}; rd_n = rd; end
            OP_OR:   begin ctrl_n = {4'b1000, ALU_OR};  rd_n = rd; end
            OP_ADDI: begin ctrl_n = {4'b1001, ALU_ADD}; rd_n = rd; imm_n = imm_ext; end
            OP_ANDI: begin ctrl_n = {4'b1001, ALU_AND}; rd_n = rd; imm_n = imm_ext; end
            OP_LW:   begin ctrl_n = {4'b1101, ALU_ADD}; rd_n = rd; imm_n = imm_ext; end
            OP_SW:   begin ctrl_n = {4'b0011, ALU_ADD}; imm_n = imm_ext; end
            // Link register gets the return address through the ALU as NPC + 0.
            OP_CALL: begin ctrl_n = {4'b1001, ALU_ADD}; rd_n = 4'd15; a_n = bus.NPC_F; end
            default: ;
        endcase
    end

    logic [5:0]  ctrl_p1;
    logic [3:0]  rd_p1;
    logic [31:0] a_p1, b_p1, imm_p1, npc_p1;

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk) begin
        if (reset || stall) begin
            ctrl_p1 <= 6'd0;
            rd_p1   <= 4'd0;
            a_p1    <= 32'd0;
            b_p1    <= 32'd0;
            imm_p1  <= 32'd0;
            npc_p1  <= 32'd0;
        end else begin
            ctrl_p1 <= ctrl_n;
            rd_p1   <= rd_n;
            a_p1    <= a_n;
            b_p1    <= b_n;
            imm_p1  <= imm_n;
            npc_p1  <= bus.NPC_F;
        end
    end

    assign bus.Ctrl_D = ctrl_p1;
    assign bus.Rd_D   = rd_p1;
    assign bus.A_D    = a_p1;
    assign bus.B_D    = b_p1;
    assign bus.Imm_D  = imm_p1;
    assign bus.NPC_D  = npc_p1;

`ifdef ID_FWD_EN
    assign bus.stall_count = '0;
`else
    logic [STALL_CNT_W-1:0] stall_cnt_p1;

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_p1 <= '0;
        else if (stall)
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end

    assign bus.stall_count = stall_cnt_p1;
`endif
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed scenarios plus random decode traffic against a
// behavioural model; combinational fetch controls and the ID/EX latch are checked separately.
module tb_id_stage;
    localparam int SCW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_stage_if #(.STALL_CNT_W(SCW)) bus ();
    id_stage #(.STALL_CNT_W(SCW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {
        logic [1:0]  pcsrc;
        logic [31:0] off, regrs;
        logic        kill, dis;
        logic [3:0]  ra, rb;
    } comb_t;

    typedef struct {
        logic [5:0]     ctrl;
        logic [3:0]     rd;
        logic [31:0]    a, b, imm, npc;
        logic [SCW-1:0] cnt;
        logic           chk_rd, chk_a, chk_b, chk_imm, chk_npc;
    } lat_t;

    comb_t qc[$];
    lat_t  ql[$];
    comb_t ce;
    lat_t  le;

    logic [31:0] rf[16];
    int vectors = 0;
    int miscompares = 0;
    int mcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference operand value: register file, overridden by progressively newer producers.
    function automatic logic [31:0] operand(input logic [3:0] r);
        logic [31:0] v;
        v = (r == 4'd0) ? 32'd0 : rf[r];
`ifdef ID_FWD_EN
        if (r != 4'd0) begin
            if (bus.Fwd_W[4] && bus.Fwd_W[3:0] == r) v = bus.Result_W;
            if (bus.Fwd_M[5] && bus.Fwd_M[3:0] == r) v = bus.Result_M;
            if (bus.Fwd_E[5] && !bus.Fwd_E[4] && bus.Fwd_E[3:0] == r) v = bus.Result_E;
        end
`endif
        return v;
    endfunction

    function automatic logic hazard(input logic [3:0] r);
        if (r == 4'd0) return 1'b0;
`ifdef ID_FWD_EN
        return bus.Fwd_E[5] && bus.Fwd_E[4] && bus.Fwd_E[3:0] == r;
`else
        return (bus.Fwd_E[5] && bus.Fwd_E[3:0] == r) || (bus.Fwd_M[5] && bus.Fwd_M[3:0] == r) ||
               (bus.Fwd_W[4] && bus.Fwd_W[3:0] == r);
`endif
    endfunction

    task automatic model_step(input logic rst);
        logic [31:0] ins, a, b, npc;
        logic [5:0]  op;
        logic [3:0]  rs, rt;
        logic        use_s, use_t, stall;
        logic signed [31:0] s14, s26;
        comb_t c;
        lat_t  l;
        ins = bus.Instruction_F;
        npc = bus.NPC_F;
        op  = ins[31:26];
        rs  = ins[21:18];
        rt  = ins[17:14];
        s14 = $signed(ins[13:0]);
        s26 = $signed(ins[25:0]);
        use_s = (op >= 6'd1 && op <= 6'd10) || op == 6'd13;
        use_t = (op >= 6'd1 && op <= 6'd4) || (op >= 6'd8 && op <= 6'd10);
        a = operand(rs);
        b = operand(rt);
        stall = (use_s && hazard(rs)) || (use_t && hazard(rt));

        c.ra = rs; c.rb = rt; c.dis = stall; c.pcsrc = 2'd0; c.off = '0; c.regrs = '0;
        if (!stall) begin
            if (op == 6'd11 || op == 6'd12) begin c.pcsrc = 2'd1; c.off = npc + s26; end
            else if ((op == 6'd9 && a == b) || (op == 6'd10 && a != b)) begin
                c.pcsrc = 2'd1; c.off = npc + s14;
            end
            else if (op == 6'd13) begin c.pcsrc = 2'd2; c.regrs = a; end
        end
        c.kill = (c.pcsrc != 2'd0);
        qc.push_back(c);

        l = '{default: '0};
        if (rst || stall) begin
            l.chk_rd = 1'b1; l.chk_a = 1'b1; l.chk_b = 1'b1; l.chk_imm = 1'b1; l.chk_npc = rst;
        end else begin
            case (op)
                6'd1:  l.ctrl = 6'b100000;
                6'd2:  l.ctrl = 6'b100001;
                6'd3:  l.ctrl = 6'b100010;
                6'd4:  l.ctrl = 6'b100011;
                6'd5:  l.ctrl = 6'b100100;
                6'd6:  l.ctrl = 6'b100110;
                6'd7:  l.ctrl = 6'b110100;
                6'd8:  l.ctrl = 6'b001100;
                6'd12: l.ctrl = 6'b100100;
                default: l.ctrl = 6'b000000;
            endcase
            l.rd = (op == 6'd12) ? 4'd15 : ins[25:22];
            l.a = (op == 6'd12) ? npc : a;
            l.b = b;
            l.imm = (op == 6'd6) ? {18'd0, ins[13:0]} : (op == 6'd12) ? 32'd0 : s14;
            l.npc = npc;
            l.chk_rd = l.ctrl[5];
            l.chk_a = use_s || op == 6'd12;
            l.chk_b = use_t;
            l.chk_imm = (op >= 6'd5 && op <= 6'd8) || op == 6'd12;
            l.chk_npc = 1'b1;
        end
`ifndef ID_FWD_EN
        if (rst) mcnt = 0;
        else if (stall && mcnt < (1 << SCW) - 1) mcnt++;
`endif
        l.cnt = mcnt[SCW-1:0];
        ql.push_back(l);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] npc,
                         input logic [5:0] fe, input logic [31:0] re,
                         input logic [5:0] fm, input logic [31:0] rm,
                         input logic [4:0] fw, input logic [31:0] rw, input logic rst);
        @(negedge clk);
        reset = rst;
        bus.Instruction_F = ins;
        bus.NPC_F = npc;
        bus.Fwd_E = fe; bus.Result_E = re;
        bus.Fwd_M = fm; bus.Result_M = rm;
        bus.Fwd_W = fw; bus.Result_W = rw;
        bus.RegA_data = (ins[21:18] == 4'd0) ? 32'd0 : rf[ins[21:18]];
        bus.RegB_data = (ins[17:14] == 4'd0) ? 32'd0 : rf[ins[17:14]];
        model_step(rst);
    endtask

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [31:0] rnd_val();
        return ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
    endfunction

    always @(negedge clk) begin
        #2;
        if (qc.size() > 0) begin
            ce = qc.pop_front();
            chk("RegA_addr", {28'd0, bus.RegA_addr}, {28'd0, ce.ra});
            chk("RegB_addr", {28'd0, bus.RegB_addr}, {28'd0, ce.rb});
            chk("PCsrc", {30'd0, bus.PCsrc}, {30'd0, ce.pcsrc});
            chk("KILL", {31'd0, bus.KILL}, {31'd0, ce.kill});
            chk("disable_PC", {31'd0, bus.disable_PC}, {31'd0, ce.dis});
            chk("disable_IR", {31'd0, bus.disable_IR}, {31'd0, ce.dis});
            if (ce.pcsrc == 2'd1) chk("PC_offset", bus.PC_offset, ce.off);
            if (ce.pcsrc == 2'd2) chk("PC_regRs", bus.PC_regRs, ce.regrs);
        end
    end

    always @(posedge clk) begin
        #1;
        if (ql.size() > 0) begin
            le = ql.pop_front();
            chk("Ctrl_D", {26'd0, bus.Ctrl_D}, {26'd0, le.ctrl});
            if (le.chk_rd)  chk("Rd_D", {28'd0, bus.Rd_D}, {28'd0, le.rd});
            if (le.chk_a)   chk("A_D", bus.A_D, le.a);
            if (le.chk_b)   chk("B_D", bus.B_D, le.b);
            if (le.chk_imm) chk("Imm_D", bus.Imm_D, le.imm);
            if (le.chk_npc) chk("NPC_D", bus.NPC_D, le.npc);
            chk("stall_count", 32'(bus.stall_count), 32'(le.cnt));
        end
    end

    initial begin
        logic [31:0] ins;
        logic [5:0]  op;
        rf[0] = 32'd0;
        for (int i = 1; i < 16; i++) rf[i] = $urandom;

        repeat (3) drive(32'd0, 32'd0, 6'd0, 32'd0, 6'd0, 32'd0, 5'd0, 32'd0, 1'b1);
        // EX forward into Rs of ADD R3,R1,R2
        drive({6'h01, 4'd3, 4'd1, 4'd2, 14'd0}, 32'h10, {2'b10, 4'd1}, 32'h55, 6'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        // Load-use on R4, then the load forwards from MEM
        drive({6'h01, 4'd5, 4'd4, 4'd2, 14'd0}, 32'h11, {2'b11, 4'd4}, 32'h0, 6'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        drive({6'h01, 4'd5, 4'd4, 4'd2, 14'd0}, 32'h11, 6'd0, 32'd0, {2'b11, 4'd4}, 32'h77, 5'd0, 32'd0, 1'b0);
        // BEQ R1,R2 taken, imm14 = -3
        rf[1] = 32'd7; rf[2] = 32'd7;
        drive({6'h09, 4'd0, 4'd1, 4'd2, 14'h3FFD}, 32'h20, 6'd0, 32'd0, 6'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        rf[5] = 32'h100;
        drive({6'h0D, 4'd0, 4'd5, 18'd0}, 32'h30, 6'd0, 32'd0, 6'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        drive({6'h0C, 26'h10}, 32'h40, 6'd0, 32'd0, 6'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        // Dependent ADD behind a producer of R1 walking through EX, MEM, WB
        drive(32'd0, 32'd0, 6'd0, 32'd0, 6'd0, 32'd0, 5'd0, 32'd0, 1'b1);
        ins = {6'h01, 4'd3, 4'd1, 4'd2, 14'd0};
        drive(ins, 32'h50, {2'b10, 4'd1}, 32'h99, 6'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        drive(ins, 32'h50, 6'd0, 32'd0, {2'b10, 4'd1}, 32'h99, 5'd0, 32'd0, 1'b0);
        drive(ins, 32'h50, 6'd0, 32'd0, 6'd0, 32'd0, {1'b1, 4'd1}, 32'h99, 1'b0);
        rf[1] = 32'h99;
        drive(ins, 32'h50, 6'd0, 32'd0, 6'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        drive(32'd0, 32'h51, 6'd0, 32'd0, 6'd0, 32'd0, 5'd0, 32'd0, 1'b0);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 15) == 0)
                for (int i = 1; i < 16; i++) rf[i] = rnd_val();
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(14, 63)) : 6'($urandom_range(0, 13));
            ins = $urandom;
            ins[31:26] = op;
            if (op != 6'h0B && op != 6'h0C) begin
                ins[21:18] = rnd_reg();
                ins[17:14] = rnd_reg();
            end
            drive(ins, $urandom,
                  {1'($urandom), 1'($urandom), rnd_reg()}, rnd_val(),
                  {1'($urandom), 1'($urandom), rnd_reg()}, rnd_val(),
                  {1'($urandom), rnd_reg()}, rnd_val(),
                  1'($urandom_range(0, 63) == 0));
        end

        repeat (2) @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage, directly downstream of the fetch stage. It consumes `Instruction_F`/`NPC_F` and reads two register-file ports. It resolves operand hazards by forwarding or stalling, and resolves jumps and branches in decode. It drives the fetch controls (`PCsrc`, `PC_offset`, `PC_regRs`, `KILL`, `disable_PC`, `disable_IR`) and registers decoded operands and controls into the ID/EX latch.

## Interface

**Parameters**
- `STALL_CNT_W`, 16: width of the saturating stall counter.

**Ports**
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `Instruction_F` in 32: fetched instruction. All-zero is a NOP/bubble.
- `NPC_F` in 32: PC+1 of that instruction.
- `RegA_addr` / `RegB_addr` out 4: register-file read addresses. They equal `Instruction_F[21:18]` and `[17:14]`.
- `RegA_data` / `RegB_data` in 32: combinational read data. R0 reads 0.
- `Fwd_E` in 6: `{RegWr, MemRd, Rd[3:0]}` of the EX-stage instruction.
- `Result_E` in 32: EX ALU result.
- `Fwd_M` in 6: `{RegWr, MemRd, Rd}` of the MEM-stage instruction.
- `Result_M` in 32: MEM result (load data or ALU result).
- `Fwd_W` in 5: `{RegWr, Rd}` of the WB-stage instruction.
- `Result_W` in 32: WB write data.
- `PCsrc` out 2: 00 = PC+1, 01 = `PC_offset`, 10 = `PC_regRs`.
- `PC_offset` out 32: jump/call/branch target.
- `PC_regRs` out 32: JR target (forwarded Rs).
- `KILL` out 1: squash the instruction being fetched.
- `disable_PC` / `disable_IR` out 1: stall fetch.
- `Ctrl_D` out 6: `{RegWr, MemRd, MemWr, ALUsrc, ALUop[1:0]}`. ALUop: 0 = ADD, 1 = SUB, 2 = AND, 3 = OR.
- `Rd_D` out 4, `A_D` out 32, `B_D` out 32, `Imm_D` out 32, `NPC_D` out 32: ID/EX latch.
- `stall_count` out `STALL_CNT_W`: count of stall cycles (present only with `ID_FWD_EN` undefined; see Configuration).

## Operation

**Encoding**
- Fields: op `[31:26]`, Rd `[25:22]`, Rs `[21:18]`, Rt `[17:14]`, imm14 `[13:0]`, imm26 `[25:0]`.
- Opcodes:
  - 00 NOP
  - 01 ADD, 02 SUB, 03 AND, 04 OR (R-type; use Rs, Rt)
  - 05 ADDI, 06 ANDI (use Rs)
  - 07 LW (Rs)
  - 08 SW (Rs, Rt)
  - 09 BEQ, 0A BNE (Rs, Rt)
  - 0B J, 0C CALL, 0D JR (Rs)
  - Undefined opcodes decode as NOP.
- Immediates: ANDI zero-extends imm14; all other imm14 uses are sign-extended.

**Operands**
- `opA` and `opB` are the forwarded Rs and Rt values.
- Source priority for each: EX (if `RegWr` and not `MemRd`) > MEM (if `RegWr`) > WB (if `RegWr`) > register file.
- A stage matches only if its Rd equals the source register and is nonzero. R0 is never forwarded and never causes a stall.

**Stall**
- `stall` = the ID instruction uses a source whose matching EX producer has `MemRd` = 1 (load-use hazard).
- During a stall:
  - `disable_PC` = `disable_IR` = 1.
  - `PCsrc` = 00, `KILL` = 0.
  - A bubble is written to ID/EX: `Ctrl_D` = 0, `Rd_D` = 0, data fields = 0.

**Redirect** (evaluated only when not stalled)
- J and CALL: `PC_offset` = `NPC_F` + sext(imm26), `PCsrc` = 01.
- BEQ/BNE: `PC_offset` = `NPC_F` + sext(imm14). `PCsrc` = 01 when taken (`opA == opB` for BEQ, `opA != opB` for BNE), else 00.
- JR: `PC_regRs` = `opA`, `PCsrc` = 10.
- `KILL` = (`PCsrc` != 00).

**ID/EX latch** (written every non-stalled cycle)
- R-type: RegWr = 1, ALUsrc = 0, `A_D` = `opA`, `B_D` = `opB`.
- ADDI/ANDI: RegWr = 1, ALUsrc = 1, `Imm_D` = extended immediate.
- LW: RegWr = 1, MemRd = 1, ALUsrc = 1, ADD.
- SW: MemWr = 1, ALUsrc = 1, `B_D` = store data.
- CALL: RegWr = 1, `Rd_D` = 15, `A_D` = `NPC_F`, `Imm_D` = 0, ALUsrc = 1, ADD.
- Branches, J, JR and NOP: `Ctrl_D` = 0.
- `NPC_D` is always `NPC_F`.

## Timing

- On reset, all registered outputs become 0 (`Ctrl_D`, `Rd_D`, `A_D`, `B_D`, `Imm_D`, `NPC_D`, `stall_count`).
- Fetch controls are combinational from the decoded instruction. They are therefore 0/00 whenever `Instruction_F` is 0, including after reset.
- Decode-to-ID/EX latency is 1 cycle.
- A redirect takes effect on the next edge. `KILL` turns the wrong-path fetch into a NOP, giving a 1-cycle penalty.
- Load-use stall: exactly 1 cycle. The next cycle the load is in MEM and `Result_M` forwards.
- Stall and redirect in the same cycle: the stall wins. The branch re-evaluates the following cycle with forwarded data.
- A write in WB and a read in ID in the same cycle: the WB forward supplies the data, so the register file's write-then-read ordering is irrelevant.
- Reset asserted mid-stall clears the latch and counter. It has no other effect.

## Configuration

- With `ID_FWD_EN` defined (forwarding build):
  - Forwarding is as described in Operation.
  - `stall_count` is not present; it is tied to 0.
- With `ID_FWD_EN` undefined (no-forwarding build):
  - All operands come from the register file.
  - `stall` = any used source matches a writing Rd in EX, MEM or WB.
  - `stall_count` increments by 1 on each stall cycle and saturates at all-ones.

## Test plan

- **Reset.** Hold `reset` with `Instruction_F` = 0 → all ID/EX outputs 0, `PCsrc` = 00, `KILL` = 0, `disable_PC` = 0.
- **EX forward.** ADD R3,R1,R2 with `Fwd_E` = {1,0,1}, `Result_E` = 0x55 → `A_D` = 0x55, no stall.
- **Load-use.** ADD using R4 while `Fwd_E` = {1,1,4} → one cycle with `disable_PC` = `disable_IR` = 1 and `Ctrl_D` = 0. The next cycle forwards from `Result_M`.
- **Branch taken.** BEQ R1,R2 with imm14 = −3, `NPC_F` = 0x20, `RegA_data` = `RegB_data` = 7 → `PCsrc` = 01, `PC_offset` = 0x1D, `KILL` = 1, `Ctrl_D` = 0.
- **JR and CALL.** JR R5 (R5 = 0x100) → `PCsrc` = 10, `PC_regRs` = 0x100. CALL with `NPC_F` = 0x40, imm26 = 0x10 → `PC_offset` = 0x50, `Rd_D` = 15, `A_D` = 0x40, RegWr = 1.
- **No-forwarding build.** With `ID_FWD_EN` undefined, a dependent ADD behind an ADD writing R1 → 3 stall cycles, `stall_count` = 3.
